edge_detect: RTL

- Pixel-stream gradient edge detector; sits directly upstream of the line-overlay stage in the Hough pipeline.
- Consumes raw 8-bit greyscale pixels with FrameIn/LineIn markers.
- Computes a horizontal plus vertical first-difference gradient using one line buffer.
- Emits a binary edge image (0xFF edge / 0x00 background) on the same marker protocol, delayed by a fixed 2 cycles.

---
 rtl/edge_detect.sv | 128 ++++++++++++
 1 files changed

// File: rtl/edge_detect.sv
// Streaming gradient edge detector: |dx| + |dy| against a threshold, one line buffer,
// binary 0xFF/0x00 output with markers kept aligned through a fixed two-stage pipeline.
module edge_detect #(
    parameter int MAX_WIDTH = 256
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] PixelIn,
    input  logic       FrameIn,
    input  logic       LineIn,
    input  logic [7:0] Threshold,
    output logic [7:0] PixelOut,
    output logic       FrameOut,
    output logic       LineOut
);

    localparam int         AW   = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [8:0] XMAX = 9'(MAX_WIDTH);

    function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
        logic signed [9:0] d;
        d = $signed({2'b00, a}) - $signed({2'b00, b});
        if (d < 0)
            d = -d;
        return d[7:0];
    endfunction

    function automatic logic [8:0] x_inc(input logic [8:0] v);
        return (v >= XMAX) ? XMAX : v + 9'd1;
    endfunction

    function automatic logic [7:0] y_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic [8:0]    x;
    logic [7:0]    y;
    logic [7:0]    pprev;
    logic          marker;
    logic          pix_vld;
    logic [AW-1:0] addr;
    logic [7:0]    h_calc;

    logic [7:0]    lb [MAX_WIDTH];
    logic [7:0]    lb_q_p1;

    logic          vld_p1;
    logic          vmask_p1;
    logic [7:0]    h_p1;
    logic [7:0]    p_p1;
    logic [7:0]    thr_p1;
    logic          frame_p1;
    logic          line_p1;

    logic [7:0]    v_calc;
    logic [8:0]    sum_calc;
    logic [7:0]    pix_p2;
    logic          frame_p2;
    logic          line_p2;

    assign marker  = FrameIn | LineIn;
    assign pix_vld = ~marker & (x < XMAX);
    assign addr    = x[AW-1:0];
    assign h_calc  = (x == 9'd0) ? 8'd0 : absdiff(PixelIn, pprev);

    // Line buffer: read-before-write, so lb_q_p1 holds the pixel from the row above.
    always_ff @(posedge Clk) begin
        lb_q_p1 <= lb[addr];
        if (pix_vld)
            lb[addr] <= PixelIn;
    end

    // Stage 1: coordinates, horizontal term, operands for the vertical term
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x        <= 9'd0;
            y        <= 8'd0;
            pprev    <= 8'd0;
            vld_p1   <= 1'b0;
            vmask_p1 <= 1'b0;
            h_p1     <= 8'd0;
            p_p1     <= 8'd0;
            thr_p1   <= 8'd0;
            frame_p1 <= 1'b0;
            line_p1  <= 1'b0;
        end else begin
            if (FrameIn) begin
                x <= 9'd0;
                y <= 8'd0;
            end else if (LineIn) begin
                x <= 9'd0;
                y <= y_inc(y);
            end else begin
                x <= x_inc(x);
            end
            if (pix_vld)
                pprev <= PixelIn;
            vld_p1   <= pix_vld;
            vmask_p1 <= (y != 8'd0);
            h_p1     <= h_calc;
            p_p1     <= PixelIn;
            thr_p1   <= Threshold;
            frame_p1 <= FrameIn;
            line_p1  <= LineIn;
        end
    end

    assign v_calc   = vmask_p1 ? absdiff(p_p1, lb_q_p1) : 8'd0;
    assign sum_calc = {1'b0, h_p1} + {1'b0, v_calc};

    // Stage 2: threshold compare into the output register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_p2   <= 8'h00;
            frame_p2 <= 1'b0;
            line_p2  <= 1'b0;
        end else begin
            pix_p2   <= (vld_p1 && (sum_calc > {1'b0, thr_p1})) ? 8'hFF : 8'h00;
            frame_p2 <= frame_p1;
            line_p2  <= line_p1;
        end
    end

    assign PixelOut = pix_p2;
    assign FrameOut = frame_p2;
    assign LineOut  = line_p2;

endmodule
